// File: rtl/histo_frame_seq.sv
// histo_frame_seq: builds an 8-bin column histogram of colour-matched pixels inside the
// inner frame, then reduces the bins over four cycles into total, left/right and edge-group
// sums, announcing fresh results with a one-cycle new_frame_proc_o pulse.
module histo_frame_seq #(
    parameter int c_img_cols        = 160,
    parameter int c_img_rows        = 120,
    parameter int c_nb_cols         = $clog2(c_img_cols),
    parameter int c_nb_rows         = $clog2(c_img_rows),
    parameter int c_inframe_col0    = 16,
    parameter int c_inframe_row0    = 8,
    parameter int c_inframe_cols    = 128,
    parameter int c_inframe_rows    = 104,
    parameter int c_hist_bins       = 8,
    parameter int c_nb_hist_val     = $clog2(c_inframe_rows*(c_inframe_cols/c_hist_bins)+1),
    parameter int c_nb_inframe_pxls = $clog2(c_inframe_cols*c_inframe_rows)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start_i,
    input  logic                           frame_end_i,
    input  logic                           pxl_valid_i,
    input  logic [c_nb_cols-1:0]           pxl_col_i,
    input  logic [c_nb_rows-1:0]           pxl_row_i,
    input  logic                           pxl_match_i,
    output logic [c_nb_inframe_pxls-1:0]   colorpxls_o,
    output logic [c_nb_hist_val-1:0]       colorpxls_bin0_o,
    output logic [c_nb_hist_val-1:0]       colorpxls_bin7_o,
    output logic [c_nb_inframe_pxls-2:0]   colorpxls_bin01_o,
    output logic [c_nb_inframe_pxls-2:0]   colorpxls_bin012_o,
    output logic [c_nb_inframe_pxls-2:0]   colorpxls_left_o,
    output logic [c_nb_inframe_pxls-2:0]   colorpxls_bin67_o,
    output logic [c_nb_inframe_pxls-2:0]   colorpxls_bin567_o,
    output logic [c_nb_inframe_pxls-2:0]   colorpxls_rght_o,
    output logic                           new_frame_proc_o,
    output logic                           busy_o
);

    localparam int c_w_grp     = c_nb_inframe_pxls - 1;
    localparam int c_nb_bin    = $clog2(c_hist_bins);
    localparam int c_bin_shift = $clog2(c_inframe_cols / c_hist_bins);

    // One extra bit so the exclusive upper bounds cannot overflow the index width.
    localparam logic [c_nb_cols:0] c_col_lo = (c_nb_cols+1)'(c_inframe_col0);
    localparam logic [c_nb_cols:0] c_col_hi = (c_nb_cols+1)'(c_inframe_col0 + c_inframe_cols);
    localparam logic [c_nb_rows:0] c_row_lo = (c_nb_rows+1)'(c_inframe_row0);
    localparam logic [c_nb_rows:0] c_row_hi = (c_nb_rows+1)'(c_inframe_row0 + c_inframe_rows);
    localparam logic [c_nb_hist_val-1:0] c_bin_max = '1;

    typedef enum logic [1:0] {StIdle, StAccum, StSum, StDone} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_pending;
    logic [1:0]                r_k;
    logic [c_nb_hist_val-1:0]  r_bins [c_hist_bins];
    logic [c_w_grp-1:0]        r_lacc;
    logic [c_w_grp-1:0]        r_racc;
    logic [c_w_grp-1:0]        w_lacc_next;
    logic [c_w_grp-1:0]        w_racc_next;
    logic [c_nb_cols:0]        w_col_ext;
    logic [c_nb_cols:0]        w_col_off;
    logic [c_nb_rows:0]        w_row_ext;
    logic                      w_in_frame;
    logic                      w_count;
    logic                      w_clr_bins;
    logic [c_nb_bin-1:0]       w_bin_idx;
    logic [c_nb_bin-1:0]       w_lidx;
    logic [c_nb_bin-1:0]       w_ridx;

    logic [c_nb_inframe_pxls-1:0] r_colorpxls;
    logic [c_nb_hist_val-1:0]     r_bin0;
    logic [c_nb_hist_val-1:0]     r_bin7;
    logic [c_w_grp-1:0]           r_bin01;
    logic [c_w_grp-1:0]           r_bin012;
    logic [c_w_grp-1:0]           r_left;
    logic [c_w_grp-1:0]           r_bin67;
    logic [c_w_grp-1:0]           r_bin567;
    logic [c_w_grp-1:0]           r_rght;

    assign w_col_ext  = {1'b0, pxl_col_i};
    assign w_row_ext  = {1'b0, pxl_row_i};
    assign w_in_frame = (w_col_ext >= c_col_lo) && (w_col_ext < c_col_hi) &&
                        (w_row_ext >= c_row_lo) && (w_row_ext < c_row_hi);
    assign w_count    = pxl_valid_i && pxl_match_i && w_in_frame;
    assign w_col_off  = w_col_ext - c_col_lo;
    assign w_bin_idx  = c_nb_bin'(w_col_off >> c_bin_shift);

    // Reduction walks bins inward from both edges: k from the left, 7-k from the right.
    assign w_lidx      = {1'b0, r_k};
    assign w_ridx      = c_nb_bin'(c_hist_bins - 1) - w_lidx;
    assign w_lacc_next = r_lacc + c_w_grp'(r_bins[w_lidx]);
    assign w_racc_next = r_racc + c_w_grp'(r_bins[w_ridx]);

    // Next-state decode; bins are cleared on every (re-)entry to accumulation.
    always_comb begin
        w_state_next = r_state;
        w_clr_bins   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (frame_start_i) begin
                    w_state_next = StAccum;
                    w_clr_bins   = 1'b1;
                end
            end
            StAccum: begin
                if (frame_start_i) begin
                    w_clr_bins = 1'b1;
                end else if (frame_end_i) begin
                    w_state_next = StSum;
                end
            end
            StSum: begin
                if (r_k == 2'd3) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (r_pending || frame_start_i) begin
                    w_state_next = StAccum;
                    w_clr_bins   = 1'b1;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Remember a frame start that arrives while the reduction is still running.
    always_ff @(posedge clk) begin
        if (rst || (r_state == StDone)) begin
            r_pending <= 1'b0;
        end else if ((r_state == StSum) && frame_start_i) begin
            r_pending <= 1'b1;
        end
    end

    // Saturating per-bin pixel counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_hist_bins; i++) begin
            if (rst || w_clr_bins) begin
                r_bins[i] <= '0;
            end else if ((r_state == StAccum) && w_count && (w_bin_idx == c_nb_bin'(i)) &&
                         (r_bins[i] != c_bin_max)) begin
                r_bins[i] <= r_bins[i] + 1'b1;
            end
        end
    end

    // Four-step reduction; results are only written here so they hold between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= '0;
            r_lacc      <= '0;
            r_racc      <= '0;
            r_colorpxls <= '0;
            r_bin0      <= '0;
            r_bin7      <= '0;
            r_bin01     <= '0;
            r_bin012    <= '0;
            r_left      <= '0;
            r_bin67     <= '0;
            r_bin567    <= '0;
            r_rght      <= '0;
        end else if (r_state == StSum) begin
            r_k    <= r_k + 2'd1;
            r_lacc <= w_lacc_next;
            r_racc <= w_racc_next;
            unique case (r_k)
                2'd0: begin
                    r_bin0 <= r_bins[0];
                    r_bin7 <= r_bins[c_hist_bins-1];
                end
                2'd1: begin
                    r_bin01 <= w_lacc_next;
                    r_bin67 <= w_racc_next;
                end
                2'd2: begin
                    r_bin012 <= w_lacc_next;
                    r_bin567 <= w_racc_next;
                end
                2'd3: begin
                    r_left      <= w_lacc_next;
                    r_rght      <= w_racc_next;
                    r_colorpxls <= c_nb_inframe_pxls'(w_lacc_next) +
                                   c_nb_inframe_pxls'(w_racc_next);
                end
                default: ;
            endcase
        end else begin
            r_k    <= '0;
            r_lacc <= '0;
            r_racc <= '0;
        end
    end

    assign colorpxls_o        = r_colorpxls;
    assign colorpxls_bin0_o   = r_bin0;
    assign colorpxls_bin7_o   = r_bin7;
    assign colorpxls_bin01_o  = r_bin01;
    assign colorpxls_bin012_o = r_bin012;
    assign colorpxls_left_o   = r_left;
    assign colorpxls_bin67_o  = r_bin67;
    assign colorpxls_bin567_o = r_bin567;
    assign colorpxls_rght_o   = r_rght;
    assign new_frame_proc_o   = (r_state == StDone);
    assign busy_o             = (r_state != StIdle);

endmodule

// File: tb/tb_histo_frame_seq.sv
// Directed bench for histo_frame_seq: a reference histogram model pushes expected results
// at each frame end; a monitor pops and compares them when new_frame_proc_o pulses.
module tb_histo_frame_seq;

    logic        clk;
    logic        rst;
    logic        frame_start_i;
    logic        frame_end_i;
    logic        pxl_valid_i;
    logic [7:0]  pxl_col_i;
    logic [6:0]  pxl_row_i;
    logic        pxl_match_i;
    logic [13:0] colorpxls_o;
    logic [10:0] colorpxls_bin0_o;
    logic [10:0] colorpxls_bin7_o;
    logic [12:0] colorpxls_bin01_o;
    logic [12:0] colorpxls_bin012_o;
    logic [12:0] colorpxls_left_o;
    logic [12:0] colorpxls_bin67_o;
    logic [12:0] colorpxls_bin567_o;
    logic [12:0] colorpxls_rght_o;
    logic        new_frame_proc_o;
    logic        busy_o;

    histo_frame_seq dut (
        .clk                (clk),
        .rst                (rst),
        .frame_start_i      (frame_start_i),
        .frame_end_i        (frame_end_i),
        .pxl_valid_i        (pxl_valid_i),
        .pxl_col_i          (pxl_col_i),
        .pxl_row_i          (pxl_row_i),
        .pxl_match_i        (pxl_match_i),
        .colorpxls_o        (colorpxls_o),
        .colorpxls_bin0_o   (colorpxls_bin0_o),
        .colorpxls_bin7_o   (colorpxls_bin7_o),
        .colorpxls_bin01_o  (colorpxls_bin01_o),
        .colorpxls_bin012_o (colorpxls_bin012_o),
        .colorpxls_left_o   (colorpxls_left_o),
        .colorpxls_bin67_o  (colorpxls_bin67_o),
        .colorpxls_bin567_o (colorpxls_bin567_o),
        .colorpxls_rght_o   (colorpxls_rght_o),
        .new_frame_proc_o   (new_frame_proc_o),
        .busy_o             (busy_o)
    );

    typedef struct {
        int tot; int b0; int b7; int b01; int b012; int left; int b67; int b567; int rght;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_pulse = 0;
    int   exp_pulses = 0;
    // Reference model: bin counts, mode 0=idle 1=accumulating 2=reducing.
    int   mb[8];
    int   mode = 0;
    int   rc = 0;
    int   pend = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to check the frame_end -> pulse latency.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (new_frame_proc_o === 1'b1) begin
            exp_t e;
            n_pulse++;
            check("pulse_has_expectation", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("latency_cycle", cyc, e.cyc);
                check("colorpxls", 32'(colorpxls_o), e.tot);
                check("bin0", 32'(colorpxls_bin0_o), e.b0);
                check("bin7", 32'(colorpxls_bin7_o), e.b7);
                check("bin01", 32'(colorpxls_bin01_o), e.b01);
                check("bin012", 32'(colorpxls_bin012_o), e.b012);
                check("left", 32'(colorpxls_left_o), e.left);
                check("bin67", 32'(colorpxls_bin67_o), e.b67);
                check("bin567", 32'(colorpxls_bin567_o), e.b567);
                check("rght", 32'(colorpxls_rght_o), e.rght);
            end
        end
    end

    function automatic void clear_model();
        for (int i = 0; i < 8; i++) mb[i] = 0;
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.b0   = mb[0];
        e.b7   = mb[7];
        e.b01  = mb[0] + mb[1];
        e.b012 = e.b01 + mb[2];
        e.left = e.b012 + mb[3];
        e.b67  = mb[6] + mb[7];
        e.b567 = e.b67 + mb[5];
        e.rght = e.b567 + mb[4];
        e.tot  = e.left + e.rght;
        e.cyc  = cyc + 5;
        sb.push_back(e);
        exp_pulses++;
    endfunction

    // Drive one cycle of inputs (sampled at the next rising edge) and advance the model.
    task automatic step(input bit r, input bit fs, input bit fe, input bit v, input bit m,
                        input int col, input int row);
        bit q;
        rst           = r;
        frame_start_i = fs;
        frame_end_i   = fe;
        pxl_valid_i   = v;
        pxl_match_i   = m;
        pxl_col_i     = 8'(col);
        pxl_row_i     = 7'(row);
        q = v && m && col >= 16 && col < 144 && row >= 8 && row < 112;
        if (r) begin
            mode = 0;
            rc = 0;
            pend = 0;
            clear_model();
            exp_pulses -= sb.size();
            sb.delete();
        end else if (mode == 0) begin
            if (fs) begin
                clear_model();
                mode = 1;
            end
        end else if (mode == 1) begin
            if (fs) begin
                clear_model();
            end else begin
                if (q && mb[(col - 16) / 16] < 2047) mb[(col - 16) / 16]++;
                if (fe) begin
                    push_expected();
                    mode = 2;
                    rc = 5;
                    pend = 0;
                end
            end
        end else begin
            if (fs) pend = 1;
            rc--;
            if (rc == 0) begin
                if (pend != 0) begin
                    clear_model();
                    mode = 1;
                end else begin
                    mode = 0;
                end
                pend = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Run idle cycles until every expected result has been consumed, within a budget.
    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_colorpxls", 32'(colorpxls_o), 32'd0);
        check("rst_left", 32'(colorpxls_left_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_pulse", 32'(new_frame_proc_o), 32'd0);

        // Empty frame.
        step(0, 1, 0, 0, 0, 0, 0);
        check("busy_accum", 32'(busy_o), 32'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        drain("drain_empty");

        // Full inner frame, frame_end coinciding with the last pixel.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int r = 8; r < 112; r++) begin
            for (int c = 16; c < 144; c++) begin
                step(0, 0, (r == 111 && c == 143), 1, 1, c, r);
            end
        end
        drain("drain_full");

        // Mixed in-frame / out-of-frame pixels.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) step(0, 0, 0, 1, 1, 20, 8 + (i % 104));
        for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 1, 140, 60);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 1, 10, 60);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 1, 60, 115);
        step(0, 0, 1, 0, 0, 0, 0);
        drain("drain_mixed");

        // Frame boundaries, random in-frame pixels, unqualified pixels.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 15, 50);
        step(0, 0, 0, 1, 1, 16, 50);
        step(0, 0, 0, 1, 1, 31, 50);
        step(0, 0, 0, 1, 1, 32, 50);
        step(0, 0, 0, 1, 1, 143, 50);
        step(0, 0, 0, 1, 1, 144, 50);
        step(0, 0, 0, 1, 1, 70, 7);
        step(0, 0, 0, 1, 1, 70, 8);
        step(0, 0, 0, 1, 1, 70, 111);
        step(0, 0, 0, 1, 1, 70, 112);
        step(0, 0, 0, 0, 1, 70, 50);
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0, 1, 1, $urandom_range(16, 143), $urandom_range(8, 111));
        end
        step(0, 0, 1, 0, 0, 0, 0);
        drain("drain_boundary");

        // Valid but never matching.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) step(0, 0, 0, 1, 0, 16 + (i % 128), 50);
        step(0, 0, 1, 0, 0, 0, 0);
        drain("drain_nomatch");

        // Abort in ACCUM: only the last 10 pixels survive.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 1, 100, 50);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 100, 50);
        step(0, 0, 1, 0, 0, 0, 0);
        drain("drain_abort");

        // frame_start during SUM step 2 queues the next frame.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 1, 40 + i, 30);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        step(0, 1, 0, 1, 1, 20, 50);
        step(0, 0, 0, 1, 1, 20, 50);
        drain("drain_pending");
        idle(1);
        check("busy_after_pending", 32'(busy_o), 32'd1);
        for (int i = 0; i < 25; i++) step(0, 0, 0, 1, 1, 130, 90);
        step(0, 0, 1, 0, 0, 0, 0);
        drain("drain_after_pending");

        // Reset during SUM discards the frame.
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1, 20, 50);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0);
        check("sumrst_bin0", 32'(colorpxls_bin0_o), 32'd0);
        check("sumrst_bin01", 32'(colorpxls_bin01_o), 32'd0);
        check("sumrst_busy", 32'(busy_o), 32'd0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(8);
        check("idle_ignores_end", 32'(busy_o), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 90, 40);
        step(0, 0, 1, 0, 0, 0, 0);
        drain("drain_recover");

        idle(3);
        check("pulse_count", n_pulse, exp_pulses);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
